// File: rtl/mvb_rx_pkg.sv
// rtl/mvb_rx_pkg.sv - shared constants and write-FSM encoding for the MVB receive frame store
//
// Purpose: error-vector bit positions, write-FSM state type and default
//          geometry of the frame store (word width, words per slot, slots).
// Ports:   none (package).

package mvb_rx_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int WORDS_MAX_DEF = 16;
    localparam int SLOTS_DEF     = 2;
    localparam int ERR_W_DEF     = 5;

    // Bit positions inside err_in / rd_err; rd_err additionally carries
    // the overflow flag at bit ERR_W.
    localparam int ERR_LEN   = 0;
    localparam int ERR_SIG   = 1;
    localparam int ERR_DELIM = 2;
    localparam int ERR_QUAL  = 3;
    localparam int ERR_CRC   = 4;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_CAPTURE = 2'd1,
        WR_DROP    = 2'd2
    } wr_state_t;

endpackage

// File: rtl/mvb_frame_ram.sv
// rtl/mvb_frame_ram.sv - simple dual-port frame buffer RAM with registered read
//
// Purpose: storage for all frame slots, addressed as {slot, index}.
// Ports:   clk, rst (async active-low, clears only the read register),
//          we/waddr/wdata (synchronous write), raddr/rdata (1-cycle read).

module mvb_frame_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array contents are deliberately not reset so the storage maps to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mvb_rx_frame_store.sv
// rtl/mvb_rx_frame_store.sv - multi-slot frame store between MVB deserializer and reader
//
// Purpose: captures decoded words of a frame into a free slot, tags it with
//          length and error status on commit, presents committed frames
//          oldest-first with a random-access read port and release handshake.
// Ports:   clk, rst (async active-low)
//          capture side: frame_start, word_valid, word_data, frame_over, err_in
//          read side:    rd_ready, rd_len, rd_err, rd_addr, rd_data, rd_release
//          status:       drop_cnt (saturating), busy

module mvb_rx_frame_store
    import mvb_rx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WORDS_MAX = WORDS_MAX_DEF,
    parameter int SLOTS     = SLOTS_DEF,
    parameter int ERR_W     = ERR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         word_valid,
    input  logic [DATA_W-1:0]            word_data,
    input  logic                         frame_over,
    input  logic [ERR_W-1:0]             err_in,
    output logic                         rd_ready,
    output logic [$clog2(WORDS_MAX):0]   rd_len,
    output logic [ERR_W:0]               rd_err,
    input  logic [$clog2(WORDS_MAX)-1:0] rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         rd_release,
    output logic [7:0]                   drop_cnt,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(WORDS_MAX);
    localparam int LEN_W  = IDX_W + 1;
    localparam int SLOT_W = $clog2(SLOTS);

    wr_state_t state, state_next;

    logic [LEN_W-1:0]  wcnt;
    logic              ovf;
    logic [SLOT_W-1:0] wptr, rptr;
    logic [SLOTS-1:0]  slot_full;
    logic [LEN_W-1:0]  slot_len [SLOTS];
    logic [ERR_W:0]    slot_err [SLOTS];

    logic room;
    logic slot_free;
    logic start_new;
    logic restart;
    logic ram_we;
    logic ovf_now;
    logic commit;
    logic drop_done;
    logic release_ok;

    assign room       = (wcnt < LEN_W'(WORDS_MAX));
    // Availability looks only at registered state: a release in the same
    // cycle as frame_start does not free the slot for this frame.
    assign slot_free  = !slot_full[wptr];
    assign release_ok = rd_release && slot_full[rptr];

    // ---------------- write FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            WR_IDLE: begin
                if (frame_start) begin
                    state_next = slot_free ? WR_CAPTURE : WR_DROP;
                end
            end
            WR_CAPTURE: begin
                if (frame_over) begin
                    state_next = WR_IDLE;
                end
            end
            WR_DROP: begin
                if (frame_over) begin
                    state_next = WR_IDLE;
                end
            end
            default: state_next = WR_IDLE;
        endcase
    end

    // ---------------- write FSM: outputs ----------------
    // frame_over wins over a coincident frame_start; otherwise frame_start
    // in CAPTURE abandons the partial frame and restarts in the same slot.
    always_comb begin
        busy      = (state != WR_IDLE);
        start_new = (state == WR_IDLE) && frame_start;
        restart   = (state == WR_CAPTURE) && frame_start && !frame_over;
        ram_we    = (state == WR_CAPTURE) && word_valid && room && !restart;
        ovf_now   = (state == WR_CAPTURE) && word_valid && !room && !restart;
        // A word strobed with frame_over counts toward the non-empty test.
        commit    = (state == WR_CAPTURE) && frame_over && ((wcnt != '0) || ram_we);
        drop_done = (state == WR_DROP) && frame_over;
    end

    // ---------------- capture datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (start_new || restart) begin
                wcnt <= '0;
                ovf  <= 1'b0;
            end else begin
                if (ram_we) begin
                    wcnt <= wcnt + LEN_W'(1);
                end
                if (ovf_now) begin
                    ovf <= 1'b1;
                end
            end
            if (drop_done && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // ---------------- slot bookkeeping ----------------
    // Commit and release never target the same slot (commit needs a FREE
    // slot, release a FULL one), so both can update in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            slot_full <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_len[i] <= '0;
                slot_err[i] <= '0;
            end
        end else begin
            if (release_ok) begin
                slot_full[rptr] <= 1'b0;
                rptr            <= rptr + SLOT_W'(1);
            end
            if (commit) begin
                slot_full[wptr] <= 1'b1;
                slot_len[wptr]  <= wcnt + LEN_W'(ram_we);
                slot_err[wptr]  <= {ovf | ovf_now, err_in};
                wptr            <= wptr + SLOT_W'(1);
            end
        end
    end

    assign rd_ready = slot_full[rptr];
    assign rd_len   = slot_len[rptr];
    assign rd_err   = slot_err[rptr];

    mvb_frame_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (SLOT_W + IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr ({wptr, wcnt[IDX_W-1:0]}),
        .wdata (word_data),
        .raddr ({rptr, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mvb_rx_frame_store.sv
// tb/tb_mvb_rx_frame_store.sv - directed self-checking bench for mvb_rx_frame_store

module tb_mvb_rx_frame_store;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        word_valid;
    logic [15:0] word_data;
    logic        frame_over;
    logic [4:0]  err_in;
    logic        rd_ready;
    logic [4:0]  rd_len;
    logic [5:0]  rd_err;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_release;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mvb_rx_frame_store dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .frame_over  (frame_over),
        .err_in      (err_in),
        .rd_ready    (rd_ready),
        .rd_len      (rd_len),
        .rd_err      (rd_err),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_release  (rd_release),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start = 1'b0;
        word_valid  = 1'b0;
        frame_over  = 1'b0;
        rd_release  = 1'b0;
        err_in      = '0;
    endtask

    task automatic do_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_word(input logic [15:0] d);
        word_valid = 1'b1;
        word_data  = d;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic do_over(input logic [4:0] e);
        frame_over = 1'b1;
        err_in     = e;
        tick();
        frame_over = 1'b0;
        err_in     = '0;
    endtask

    task automatic do_release();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    task automatic set_addr(input logic [3:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr   = '0;
        word_data = '0;
        rst       = 1'b0;
        repeat (3) tick();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %0b want 0", rd_ready); end
        checks++; if (rd_len !== 5'd0) begin errors++; $display("FAIL reset_rd_len got %0d want 0", rd_len); end
        checks++; if (rd_err !== 6'd0) begin errors++; $display("FAIL reset_rd_err got %b want 000000", rd_err); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
        do_word(16'h1111);
        do_word(16'h2222);
        do_word(16'h3333);
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL basic_partial_hidden got %0b want 0", rd_ready); end
        do_over(5'b00000);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL basic_rd_ready got %0b want 1", rd_ready); end
        checks++; if (rd_len !== 5'd3) begin errors++; $display("FAIL basic_rd_len got %0d want 3", rd_len); end
        checks++; if (rd_err !== 6'd0) begin errors++; $display("FAIL basic_rd_err got %b want 000000", rd_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %0b want 0", busy); end
        set_addr(4'd2);
        checks++; if (rd_data !== 16'h3333) begin errors++; $display("FAIL basic_rd_data2 got %h want 3333", rd_data); end
        set_addr(4'd0);
        checks++; if (rd_data !== 16'h1111) begin errors++; $display("FAIL basic_rd_data0 got %h want 1111", rd_data); end
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL basic_released got %0b want 0", rd_ready); end
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 18; i++) do_word(16'h0100 + 16'(i));
        do_over(5'b00000);
        checks++; if (rd_len !== 5'd16) begin errors++; $display("FAIL ovf_rd_len got %0d want 16", rd_len); end
        checks++; if (rd_err !== 6'b100000) begin errors++; $display("FAIL ovf_rd_err got %b want 100000", rd_err); end
        for (int i = 0; i < 16; i++) begin
            set_addr(4'(i));
            checks++;
            if (rd_data !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("FAIL ovf_rd_data[%0d] got %h want %h", i, rd_data, 16'h0100 + 16'(i));
            end
        end
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL ovf_released got %0b want 0", rd_ready); end
    endtask

    task automatic test_drop();
        do_start(); do_word(16'hA000); do_over(5'b00001);
        do_start(); do_word(16'hB000); do_word(16'hB001); do_over(5'b00010);
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %0b want 1", busy); end
        do_word(16'hC000);
        do_over(5'b00000);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
        checks++; if (rd_len !== 5'd1) begin errors++; $display("FAIL drop_first_len got %0d want 1", rd_len); end
        checks++; if (rd_err !== 6'b000001) begin errors++; $display("FAIL drop_first_err got %b want 000001", rd_err); end
        set_addr(4'd0);
        checks++; if (rd_data !== 16'hA000) begin errors++; $display("FAIL drop_first_data got %h want a000", rd_data); end
        do_release();
        checks++; if (rd_len !== 5'd2) begin errors++; $display("FAIL drop_second_len got %0d want 2", rd_len); end
        checks++; if (rd_err !== 6'b000010) begin errors++; $display("FAIL drop_second_err got %b want 000010", rd_err); end
        set_addr(4'd1);
        checks++; if (rd_data !== 16'hB001) begin errors++; $display("FAIL drop_second_data got %h want b001", rd_data); end
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL drop_empty got %0b want 0", rd_ready); end
        // Release on an empty store must not move the read pointer.
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL drop_empty_release got %0b want 0", rd_ready); end
    endtask

    task automatic test_same_cycle();
        do_start();
        do_word(16'h4444);
        word_valid = 1'b1;
        word_data  = 16'h5555;
        do_over(5'b10000);
        word_valid = 1'b0;
        checks++; if (rd_len !== 5'd2) begin errors++; $display("FAIL same_rd_len got %0d want 2", rd_len); end
        checks++; if (rd_err !== 6'b010000) begin errors++; $display("FAIL same_rd_err got %b want 010000", rd_err); end
        set_addr(4'd1);
        checks++; if (rd_data !== 16'h5555) begin errors++; $display("FAIL same_rd_data1 got %h want 5555", rd_data); end
        do_release();
    endtask

    task automatic test_restart();
        do_start();
        do_word(16'h1234);
        do_word(16'h5678);
        do_start();
        do_word(16'hABCD);
        do_over(5'b00000);
        checks++; if (rd_len !== 5'd1) begin errors++; $display("FAIL restart_rd_len got %0d want 1", rd_len); end
        set_addr(4'd0);
        checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL restart_rd_data got %h want abcd", rd_data); end
        do_release();
        // A frame with no words is discarded.
        do_start();
        do_over(5'b00100);
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL empty_frame_ready got %0b want 0", rd_ready); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL empty_frame_drop got %0d want 1", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        // D into one slot, then commit E while releasing D in the same cycle.
        do_start(); do_word(16'hD000); do_over(5'b00000);
        do_start(); do_word(16'hE000);
        rd_release = 1'b1;
        do_over(5'b01000);
        rd_release = 1'b0;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", rd_ready); end
        checks++; if (rd_err !== 6'b001000) begin errors++; $display("FAIL b2b_err got %b want 001000", rd_err); end
        set_addr(4'd0);
        checks++; if (rd_data !== 16'hE000) begin errors++; $display("FAIL b2b_data got %h want e000", rd_data); end
        // Fill the second slot, then start a frame with a coincident release.
        do_start(); do_word(16'hF000); do_over(5'b00000);
        frame_start = 1'b1;
        do_release();
        frame_start = 1'b0;
        do_word(16'h9999);
        do_over(5'b00000);
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop_cnt got %0d want 2", drop_cnt); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_f_ready got %0b want 1", rd_ready); end
        set_addr(4'd0);
        checks++; if (rd_data !== 16'hF000) begin errors++; $display("FAIL b2b_f_data got %h want f000", rd_data); end
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", rd_ready); end
    endtask

    task automatic test_reset_mid();
        do_start(); do_word(16'h6666); do_over(5'b00000);
        do_start(); do_word(16'h6667);
        rst = 1'b0;
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0b want 0", rd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_drop got %0d want 0", drop_cnt); end
        tick();
        rst = 1'b1;
        tick();
        do_start(); do_word(16'h7777); do_word(16'h7778); do_over(5'b00000);
        checks++; if (rd_len !== 5'd2) begin errors++; $display("FAIL rstmid_len got %0d want 2", rd_len); end
        set_addr(4'd1);
        checks++; if (rd_data !== 16'h7778) begin errors++; $display("FAIL rstmid_data got %h want 7778", rd_data); end
        do_release();
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_released got %0b want 0", rd_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_drop();
        test_same_cycle();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvb_rx_frame_store.md
Name: mvb_rx_frame_store

Overview:
Parametrised frame store that sits after the MVB deserializer and replaces the single FIFO plus 16-word readout array. It captures decoded 16-bit words of one frame into one of SLOTS frame buffers and tags each frame with its length and an error status. Committed frames are presented oldest-first to a reader through a random-access read port with an explicit release handshake. All logic runs in the single system clock; the 3 MHz bit rate reaches the block as a one-cycle word strobe, not as a derived clock.

Parameters:
DATA_W, 16, word width.
WORDS_MAX, 16, maximum words per frame slot; must be a power of two, at least 2.
SLOTS, 2, number of frame buffers; must be a power of two, at least 2.
ERR_W, 5, error vector width: {crc, quality, delimiter, signal, length}.

Ports:
clk  in  1  system clock (24 MHz)
rst  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse: a new frame begins
word_valid  in  1  one-cycle strobe: word_data holds a decoded word
word_data  in  DATA_W  decoded word
frame_over  in  1  one-cycle pulse: end of frame
err_in  in  ERR_W  error flags; sampled on the frame_over cycle
rd_ready  out  1  at least one committed frame is available
rd_len  out  $clog2(WORDS_MAX)+1  word count of the oldest committed frame
rd_err  out  ERR_W  error vector of the oldest frame, with bit overflow appended as MSB (total ERR_W+1 bits)
rd_addr  in  $clog2(WORDS_MAX)  word index within the oldest frame
rd_data  out  DATA_W  word at rd_addr; registered, 1-cycle latency
rd_release  in  1  one-cycle pulse: free the oldest frame
drop_cnt  out  8  frames dropped because no slot was free; saturates at 255
busy  out  1  capture in progress

Behaviour:
- Reset values: rd_ready 0, rd_len 0, rd_err 0, rd_data 0, drop_cnt 0, busy 0. All slots are FREE, and the write and read pointers are 0. Buffer RAM contents are not reset.
- Write FSM states: IDLE, CAPTURE, DROP.
  - IDLE + frame_start: go to CAPTURE if a slot is free, otherwise go to DROP. Word count wcnt is cleared to 0.
  - CAPTURE + word_valid: if wcnt < WORDS_MAX, write the word to slot[wptr][wcnt] and increment wcnt. Otherwise discard the word and set ovf.
  - CAPTURE + frame_over:
    - If wcnt > 0 (counting a word that arrives in the same cycle), commit: store len = wcnt, err = {ovf, err_in}, mark the slot FULL, advance wptr mod SLOTS, and return to IDLE.
    - If wcnt = 0, discard the frame and return to IDLE.
  - CAPTURE + frame_start (no preceding frame_over): discard the partial frame and restart CAPTURE in the same slot with wcnt = 0 and ovf = 0.
  - DROP + frame_over: increment drop_cnt (saturating) and return to IDLE. word_valid is ignored in DROP.
  - frame_over or word_valid while in IDLE: ignored.
- busy is 1 in CAPTURE or DROP.
- Same-cycle word_valid and frame_over: the word is stored first, then the frame is committed including that word.
- Read side:
  - rd_ready = slot[rptr] is FULL.
  - rd_len and rd_err reflect slot[rptr] combinationally from the stored registers.
  - rd_data = slot[rptr][rd_addr], registered one cycle after rd_addr. Its value is don't-care when rd_ready = 0 or rd_addr >= rd_len.
  - rd_release with rd_ready = 1: mark slot[rptr] FREE and advance rptr mod SLOTS. rd_release with rd_ready = 0 is ignored.
- Simultaneous commit and release on different slots: both take effect in the same cycle.
- Full condition for a new frame: a release in the same cycle as frame_start does not make room. Slot availability is evaluated from the registered state only.
- Slot pointers wrap modulo SLOTS. No partial frame is ever visible to the reader.
- Reset mid-operation returns to IDLE with all slots FREE. Captured frames are lost.

Decomposition:
- Package mvb_rx_pkg: error-bit index constants (ERR_LEN=0, ERR_SIG=1, ERR_DELIM=2, ERR_QUAL=3, ERR_CRC=4), write-FSM state encoding, and the default DATA_W / WORDS_MAX / SLOTS values.
- One sub-module, mvb_frame_ram: simple dual-port RAM, depth SLOTS*WORDS_MAX, one synchronous write port, one registered read port. The address is {slot, index}.

Test Plan:
1. Reset, then frame_start, 3 words (0x1111, 0x2222, 0x3333), frame_over with err_in=0 -> rd_ready=1, rd_len=3, rd_err=0; rd_addr=2 gives rd_data=0x3333 one cycle later; rd_release sets rd_ready=0.
2. Frame of 18 words (WORDS_MAX=16) -> rd_len=16, rd_err[5]=1 (overflow); words 0..15 read back correctly, words 16 and 17 absent.
3. Three frames without any release (SLOTS=2) -> the first two are readable in order, drop_cnt=1; after two releases rd_ready=0.
4. Last word_valid in the same cycle as frame_over, err_in=5'b10000 -> that word is included in rd_len; rd_err=6'b010000 (CRC error).
5. frame_start, 2 words, frame_start again, 1 word (0xABCD), frame_over -> single frame with rd_len=1 and rd_data[0]=0xABCD.
6. rst asserted low mid-CAPTURE with one frame FULL -> rd_ready=0, busy=0, drop_cnt=0; next frame is captured into slot 0.
